// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 byte demultiplexer.
// Optional accept counter is enabled by DEMUX_STATS_EN.
package demux_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 16;
  localparam int DW    = 8;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

endpackage

// File: rtl/demux_1x8_8bit_buf_if.sv
// Producer stream plus eight consumer channels of the demultiplexer.
// xfer_cnt exists only when DEMUX_STATS_EN is defined.
interface demux_1x8_8bit_buf_if;
  import demux_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic [DW-1:0]    D;
  logic [N_CH-1:0]  out_valid;
  logic [N_CH-1:0]  out_ready;
  logic [DW-1:0]    Y [N_CH];
`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] xfer_cnt;
`endif

  modport master (
`ifdef DEMUX_STATS_EN
    input  xfer_cnt,
`endif
    output in_valid,
    output sel,
    output D,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  Y
  );

  modport slave (
`ifdef DEMUX_STATS_EN
    output xfer_cnt,
`endif
    input  in_valid,
    input  sel,
    input  D,
    input  out_ready,
    output in_ready,
    output out_valid,
    output Y
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry holding slot: refill wins over drain, data kept when empty.
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  output logic         valid,
  output logic [W-1:0] q
);

  slot_state_t  state_q, state_d;
  logic [W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (wr_en) begin
      state_d = SLOT_FULL;
      data_d  = wr_data;
    end else if (state_q == SLOT_FULL && rd_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign q     = data_q;

endmodule

// File: rtl/demux_1x8_8bit_buf.sv
// Registered 1-to-8 byte demux with per-channel valid/ready slots.
// Define DEMUX_STATS_EN to add the 16-bit accepted-byte counter.
module demux_1x8_8bit_buf
  import demux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  demux_1x8_8bit_buf_if.slave  bus
);

  logic [N_CH-1:0] vld;
  logic [N_CH-1:0] wr_en;
  logic            rdy;
  logic            xfer;

  // ready looks only at the selected slot, so a draining slot can refill
  assign rdy  = ~vld[bus.sel] | bus.out_ready[bus.sel];
  assign xfer = bus.in_valid & rdy;

  always_comb begin
    wr_en = '0;
    wr_en[bus.sel] = xfer;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(.W(DW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[k]),
      .wr_data  (bus.D),
      .rd_ready (bus.out_ready[k]),
      .valid    (vld[k]),
      .q        (bus.Y[k])
    );
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_1x8_8bit_buf.sv
// Bench for demux_1x8_8bit_buf: queue model plus directed vectors.
module tb_demux_1x8_8bit_buf;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  demux_1x8_8bit_buf_if bus ();

  demux_1x8_8bit_buf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mq [8][$];
  logic [7:0]  ylast [8];
  logic [15:0] mcnt = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial for (int k = 0; k < 8; k++) ylast[k] = '0;

  // model: each channel is a queue of at most one byte
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        mq[k].delete();
        ylast[k] = '0;
      end
      mcnt = '0;
    end else begin
      bit acc;
      int s;
      s = int'(bus.sel);
      acc = bus.in_valid && (mq[s].size() == 0 || bus.out_ready[s]);
      for (int k = 0; k < 8; k++)
        if (bus.out_ready[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      if (acc) begin
        mq[s].push_back(bus.D);
        ylast[s] = bus.D;
        mcnt = mcnt + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [7:0] ev;
      int s;
      s = int'(bus.sel);
      for (int k = 0; k < 8; k++) ev[k] = (mq[k].size() > 0);
      chk("m_out_valid", 32'(bus.out_valid), 32'(ev));
      chk("m_in_ready", 32'(bus.in_ready),
          32'(mq[s].size() == 0 || bus.out_ready[s]));
      for (int k = 0; k < 8; k++)
        chk($sformatf("m_Y%0d", k), 32'(bus.Y[k]), 32'(ylast[k]));
`ifdef DEMUX_STATS_EN
      chk("m_xfer_cnt", 32'(bus.xfer_cnt), 32'(mcnt));
`endif
    end
  end

  task automatic drv(input logic v, input logic [2:0] s,
                     input logic [7:0] d, input logic [7:0] r);
    bus.in_valid  = v;
    bus.sel       = s;
    bus.D         = d;
    bus.out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h00);
    for (int k = 0; k < 8; k++) begin
      bus.sel = 3'(k);
      #1;
      chk($sformatf("rst_ready_sel%0d", k), 32'(bus.in_ready), 32'h1);
      chk($sformatf("rst_Y%0d", k), 32'(bus.Y[k]), 32'h0);
    end
    step();

    drv(1'b1, 3'd3, 8'hA5, 8'h00);
    step();
    drv(1'b1, 3'd3, 8'h5A, 8'h00);
    @(negedge clk);
    chk("t1_out_valid", 32'(bus.out_valid), 32'h08);
    chk("t1_Y3", 32'(bus.Y[3]), 32'hA5);
    chk("t1_second_ready", 32'(bus.in_ready), 32'h0);
    step();

    drv(1'b1, 3'd5, 8'h11, 8'h00);
    step();
    drv(1'b1, 3'd5, 8'h22, 8'h20);
    @(negedge clk);
    chk("t2_ready", 32'(bus.in_ready), 32'h1);
    chk("t2_Y5_old", 32'(bus.Y[5]), 32'h11);
    step();
    drv(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t2_Y5", 32'(bus.Y[5]), 32'h22);
    chk("t2_valid5", 32'(bus.out_valid[5]), 32'h1);
    step();
    drv(1'b0, 3'd0, 8'h00, 8'hFF);
    step();

    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 3'(i), 8'(i), 8'h00);
      @(negedge clk);
      chk($sformatf("t3_ready%0d", i), 32'(bus.in_ready), 32'h1);
      step();
    end
    drv(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t3_all_full", 32'(bus.out_valid), 32'hFF);
    chk("t3_Y7", 32'(bus.Y[7]), 32'h07);
    step();
    drv(1'b0, 3'd0, 8'h00, 8'hFF);
    step();
    drv(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t3_all_empty", 32'(bus.out_valid), 32'h00);
    chk("t3_Y4_kept", 32'(bus.Y[4]), 32'h04);
    step();

    drv(1'b1, 3'd2, 8'h33, 8'h00);
    step();
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 3'd2, 8'(8'h40 + i), 8'h00);
      @(negedge clk);
      chk($sformatf("t4_stall%0d", i), 32'(bus.in_ready), 32'h0);
      step();
    end
    drv(1'b1, 3'd6, 8'h66, 8'h00);
    @(negedge clk);
    chk("t4_Y2_held", 32'(bus.Y[2]), 32'h33);
    chk("t4_ready6", 32'(bus.in_ready), 32'h1);
    step();
    drv(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t4_out_valid", 32'(bus.out_valid), 32'h44);
    chk("t4_Y6", 32'(bus.Y[6]), 32'h66);
    step();
    drv(1'b0, 3'd0, 8'h00, 8'hFF);
    step();

    for (int i = 0; i < 200; i++) begin
      drv(1'(i % 3 != 0), 3'((i * 5) % 8), 8'((i * 7) % 256),
          8'((i * 29 + 3) % 256));
      step();
    end
    drv(1'b0, 3'd0, 8'h00, 8'hFF);
    step();

    drv(1'b1, 3'd1, 8'hC1, 8'h00);
    step();
    drv(1'b1, 3'd4, 8'hC4, 8'h00);
    step();
    drv(1'b1, 3'd7, 8'h77, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t5_out_valid", 32'(bus.out_valid), 32'h00);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t5_Y%0d", k), 32'(bus.Y[k]), 32'h0);
`ifdef DEMUX_STATS_EN
    chk("t5_cnt", 32'(bus.xfer_cnt), 32'h0);
`endif
    step();

`ifdef DEMUX_STATS_EN
    for (int i = 0; i < 65537; i++) begin
      drv(1'b1, 3'(i % 8), 8'(i), 8'hFF);
      step();
    end
    drv(1'b0, 3'd0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t6_cnt_wrap", 32'(bus.xfer_cnt), 32'h1);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
